// File: rtl/uart_periph_if.sv
// CPU-side register bus of the UART peripheral: chip select, write enable,
// 4-bit register address, 32-bit write data and combinational read data.
interface uart_periph_if;
  logic        cs;
  logic        wen;
  logic [3:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output cs, output wen, output addr, output din, input dout);
  modport slave  (input cs, input wen, input addr, input din, output dout);
endinterface

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: one transmitter, one receiver, register map
// DR(0) / CTRL(1) / STAT(2) / CPB(3), addr[3:2] ignored.
// Optional feature macro: UART_LOOPBACK_EN (CTRL[2] routes TX into RX and
// holds the TxD pin high); without it CTRL[2] reads 0.
module uart_periph #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic           clk,
  input  logic           reset,
  uart_periph_if.slave   bus,
  input  logic           RxD,
  output logic           TxD
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3} state_e;

  logic [2:0]  ctrl_q;
  logic [15:0] cpb_q;
  state_e      tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        txd_q;
  state_e      rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  rx_data_q;
  logic        rx_ready_q;
  logic        overrun_q;
  logic        frame_err_q;
  logic        rxd_meta_q;
  logic        rxd_sync_q;
  logic        rxd_prev_q;

  logic        wr_s, rd_s;
  logic        dr_wr_s, dr_rd_s, ctrl_wr_s, stat_wr_s, cpb_wr_s;
  logic        tx_busy_s, tx_start_s;
  logic        loop_s, rx_src_s;
  logic [2:0]  ctrl_d;
  logic [15:0] cpb_d;
  logic        unused_s;

  assign wr_s      = bus.cs & bus.wen;
  assign rd_s      = bus.cs & ~bus.wen;
  assign dr_wr_s   = wr_s & (bus.addr[1:0] == 2'd0);
  assign dr_rd_s   = rd_s & (bus.addr[1:0] == 2'd0);
  assign ctrl_wr_s = wr_s & (bus.addr[1:0] == 2'd1);
  assign stat_wr_s = wr_s & (bus.addr[1:0] == 2'd2);
  assign cpb_wr_s  = wr_s & (bus.addr[1:0] == 2'd3);
  assign tx_busy_s  = (tx_state_q != ST_IDLE);
  assign tx_start_s = dr_wr_s & ctrl_q[0] & ~tx_busy_s;
  assign cpb_d      = (bus.din[15:0] < 16'd2) ? 16'd2 : bus.din[15:0];
  assign unused_s   = ^{bus.din[31:16], bus.addr[3:2]};

`ifdef UART_LOOPBACK_EN
  assign ctrl_d = bus.din[2:0];
  assign loop_s = ctrl_q[2];
`else
  assign ctrl_d = {1'b0, bus.din[1:0]};
  assign loop_s = 1'b0;
`endif

  // Receiver listens to the internal TX line while looping back.
  assign rx_src_s = loop_s ? txd_q : RxD;
  assign TxD      = txd_q | loop_s;

  // Read-data mux; unused bits read as zero.
  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr[1:0])
      2'd0:    bus.dout = {24'd0, rx_data_q};
      2'd1:    bus.dout = {29'd0, ctrl_q};
      2'd2:    bus.dout = {28'd0, frame_err_q, overrun_q, tx_busy_s, rx_ready_q};
      2'd3:    bus.dout = {16'd0, cpb_q};
      default: bus.dout = 32'd0;
    endcase
  end

  // Control and bit-period registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= 3'd0;
      cpb_q  <= 16'(CLKS_PER_BIT);
    end else begin
      if (ctrl_wr_s) ctrl_q <= ctrl_d;
      if (cpb_wr_s)  cpb_q  <= cpb_d;
    end
  end

  // Transmit FSM; bit counter reloads from CPB at every bit boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        ST_IDLE: begin
          txd_q <= 1'b1;
          if (tx_start_s) begin
            tx_state_q <= ST_START;
            txd_q      <= 1'b0;
            tx_cnt_q   <= cpb_q - 16'd1;
            tx_shift_q <= bus.din[7:0];
          end
        end
        ST_START: begin
          if (tx_cnt_q == 16'd0) begin
            tx_state_q <= ST_DATA;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_bit_q   <= 3'd0;
            tx_cnt_q   <= cpb_q - 16'd1;
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_cnt_q == 16'd0) begin
            tx_cnt_q <= cpb_q - 16'd1;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= ST_STOP;
              txd_q      <= 1'b1;
            end else begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (tx_cnt_q == 16'd0) tx_state_q <= ST_IDLE;
          else                   tx_cnt_q   <= tx_cnt_q - 16'd1;
        end
        default: begin
          tx_state_q <= ST_IDLE;
          txd_q      <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchronizer plus previous-sample flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rx_src_s;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Receive FSM and status flags; FSM sets are written last so they beat clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= 16'd0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_ready_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (dr_rd_s)                   rx_ready_q  <= 1'b0;
      if (stat_wr_s && bus.din[2])   overrun_q   <= 1'b0;
      if (stat_wr_s && bus.din[3])   frame_err_q <= 1'b0;
      case (rx_state_q)
        ST_IDLE: begin
          if (ctrl_q[1] && rxd_prev_q && !rxd_sync_q) begin
            rx_state_q <= ST_START;
            rx_cnt_q   <= (cpb_q >> 1) - 16'd1;
          end
        end
        ST_START: begin
          if (rx_cnt_q == 16'd0) begin
            if (rxd_sync_q) begin
              rx_state_q <= ST_IDLE;
            end else begin
              rx_state_q <= ST_DATA;
              rx_bit_q   <= 3'd0;
              rx_cnt_q   <= cpb_q - 16'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_cnt_q == 16'd0) begin
            rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
            rx_cnt_q   <= cpb_q - 16'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= ST_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (rx_cnt_q == 16'd0) begin
            rx_state_q <= ST_IDLE;
            if (rxd_sync_q) begin
              rx_data_q  <= rx_shift_q;
              rx_ready_q <= 1'b1;
              if (rx_ready_q) overrun_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph: instance A transmits, instance B
// receives A's TxD or a bench-driven line; a byte scoreboard checks RX data.
module tb_uart_periph;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_rxd = 1'b1;
  logic tb_rxd = 1'b1;
  logic rx_sel = 1'b0;
  logic txd_a, txd_b, rxd_b;

  int checks_cnt = 0;
  int errors_cnt = 0;
  logic [7:0] sb_q[$];

  uart_periph_if bus_a();
  uart_periph_if bus_b();

  assign rxd_b = rx_sel ? tb_rxd : txd_a;

  uart_periph #(.CLKS_PER_BIT(217)) u_a (.clk(clk), .reset(reset), .bus(bus_a), .RxD(a_rxd), .TxD(txd_a));
  uart_periph #(.CLKS_PER_BIT(217)) u_b (.clk(clk), .reset(reset), .bus(bus_b), .RxD(rxd_b), .TxD(txd_b));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input int which, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    if (which == 0) begin bus_a.cs = 1'b1; bus_a.wen = 1'b1; bus_a.addr = a; bus_a.din = d; end
    else            begin bus_b.cs = 1'b1; bus_b.wen = 1'b1; bus_b.addr = a; bus_b.din = d; end
    @(posedge clk); #1;
    bus_a.cs = 1'b0; bus_a.wen = 1'b0; bus_b.cs = 1'b0; bus_b.wen = 1'b0;
  endtask

  task automatic bus_read(input int which, input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    if (which == 0) begin bus_a.cs = 1'b1; bus_a.wen = 1'b0; bus_a.addr = a; end
    else            begin bus_b.cs = 1'b1; bus_b.wen = 1'b0; bus_b.addr = a; end
    #1;
    d = (which == 0) ? bus_a.dout : bus_b.dout;
    @(posedge clk); #1;
    bus_a.cs = 1'b0; bus_b.cs = 1'b0;
  endtask

  // Poll A's tx_busy without a bus access (dout is a combinational mux).
  task automatic wait_a_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); bus_a.addr = 4'd2; #1;
      if (bus_a.dout[1] == 1'b0) begin ok = 1'b1; break; end
    end
    check_val("tx_idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_b_ready(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); bus_b.addr = 4'd2; #1;
      if (bus_b.dout[0] == 1'b1) begin ok = 1'b1; break; end
    end
    check_val("rx_ready_timeout", {31'd0, ok}, 32'd1);
  endtask

  // Pop the scoreboard, dropping stale entries, and compare with a DR read.
  task automatic read_b_dr(input string tag, input int drop);
    logic [31:0] d;
    logic [7:0]  exp = 8'd0;
    bus_read(1, 4'd0, d);
    for (int i = 0; i <= drop; i++) begin
      if (sb_q.size() == 0) begin
        check_val("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        exp = sb_q.pop_front();
      end
    end
    check_val(tag, d, {24'd0, exp});
  endtask

  task automatic send_a(input logic [7:0] b);
    sb_q.push_back(b);
    bus_write(0, 4'd0, {24'd0, b});
  endtask

  // Drive a full frame on the bench RX line at 16 clocks per bit.
  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); tb_rxd = bits[i];
      repeat (15) @(negedge clk);
    end
    @(negedge clk); tb_rxd = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  tx_byte;
    logic        exp_bit;
    int          idx;
    bit          pin_ok;

    bus_a.cs = 1'b0; bus_a.wen = 1'b0; bus_a.addr = 4'd0; bus_a.din = 32'd0;
    bus_b.cs = 1'b0; bus_b.wen = 1'b0; bus_b.addr = 4'd0; bus_b.din = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Reset values
    bus_read(0, 4'd1, d); check_val("rst_ctrl", d, 32'd0);
    bus_read(0, 4'd3, d); check_val("rst_cpb", d, 32'd217);
    bus_read(0, 4'd2, d); check_val("rst_stat", d, 32'd0);
    bus_read(0, 4'd0, d); check_val("rst_dr", d, 32'd0);
    check_val("rst_txd", {31'd0, txd_a}, 32'd1);

    // DR write with tx_en=0 is ignored
    bus_write(0, 4'd0, 32'h55);
    bus_read(0, 4'd2, d); check_val("tx_disabled_busy", d, 32'd0);
    check_val("tx_disabled_txd", {31'd0, txd_a}, 32'd1);

    for (int w = 0; w < 2; w++) begin
      bus_write(w, 4'd3, 32'd16);
      bus_write(w, 4'd1, 32'd3);
    end
    bus_read(0, 4'd1, d); check_val("ctrl_rd", d, 32'd3);

    // Frame shape of 0x6D and tx_busy window of 160 cycles
    tx_byte = 8'h6D;
    send_a(tx_byte);
    bus_a.addr = 4'd2; #1;
    for (int k = 0; k <= 160; k++) begin
      idx = k / 16;
      if (idx == 0)      exp_bit = 1'b0;
      else if (idx <= 8) exp_bit = tx_byte[idx - 1];
      else               exp_bit = 1'b1;
      check_val($sformatf("txd_c%0d", k), {31'd0, txd_a}, {31'd0, exp_bit});
      check_val($sformatf("busy_c%0d", k), {31'd0, bus_a.dout[1]}, (k < 160) ? 32'd1 : 32'd0);
      @(posedge clk); #2;
    end
    wait_b_ready(100);
    read_b_dr("rx_6d", 0);

    // Back-to-back link: each byte read back, flags clean
    foreach (sb_q[i]) sb_q.delete(i);
    for (int n = 0; n < 3; n++) begin
      case (n)
        0:       tx_byte = 8'h20;
        1:       tx_byte = 8'h30;
        default: tx_byte = 8'h0A;
      endcase
      send_a(tx_byte);
      wait_b_ready(400);
      read_b_dr($sformatf("rx_byte%0d", n), 0);
      bus_read(1, 4'd2, d);
      check_val($sformatf("rx_ready_clr%0d", n), {31'd0, d[0]}, 32'd0);
      check_val($sformatf("overrun%0d", n), {31'd0, d[2]}, 32'd0);
      wait_a_idle(400);
      repeat (30) @(negedge clk);
    end

    // Overrun: two bytes without reading DR
    send_a(8'h67); wait_a_idle(400); repeat (10) @(negedge clk);
    send_a(8'h31); wait_a_idle(400); repeat (10) @(negedge clk);
    bus_read(1, 4'd2, d); check_val("overrun_stat", d, 32'h5);
    bus_write(1, 4'd2, 32'h4);
    bus_read(1, 4'd2, d); check_val("overrun_clr", d, 32'h1);
    read_b_dr("overrun_dr", 1);
    bus_read(1, 4'd2, d); check_val("stat_after_rd", d, 32'h0);

    // Glitch rejection and framing error on a bench-driven line
    rx_sel = 1'b1; tb_rxd = 1'b1;
    repeat (5) @(negedge clk);
    tb_rxd = 1'b0; repeat (4) @(negedge clk); tb_rxd = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(1, 4'd2, d); check_val("glitch_stat", d, 32'h0);
    bus_read(1, 4'd0, d); check_val("glitch_dr", d, 32'h31);
    drive_frame(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    bus_read(1, 4'd2, d); check_val("frame_err_stat", d, 32'h8);
    bus_read(1, 4'd0, d); check_val("frame_err_dr", d, 32'h31);
    bus_write(1, 4'd2, 32'h8);
    bus_read(1, 4'd2, d); check_val("frame_err_clr", d, 32'h0);
    sb_q.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1);
    wait_b_ready(100);
    read_b_dr("rx_bench_3c", 0);
    rx_sel = 1'b0;

    // CPB floor at 2 and addr[3:2] ignored
    bus_write(1, 4'd3, 32'd1);
    bus_read(1, 4'hF, d); check_val("cpb_min1", d, 32'd2);
    bus_write(1, 4'd3, 32'hFFFF_0000);
    bus_read(1, 4'd7, d); check_val("cpb_min0", d, 32'd2);
    bus_write(1, 4'd3, 32'd16);
    bus_read(1, 4'd3, d); check_val("cpb_restore", d, 32'd16);

`ifdef UART_LOOPBACK_EN
    bus_write(0, 4'd1, 32'd7);
    bus_read(0, 4'd1, d); check_val("loop_ctrl", d, 32'd7);
    sb_q.push_back(8'hA5);
    bus_write(0, 4'd0, 32'hA5);
    pin_ok = 1'b1;
    idx = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); bus_a.addr = 4'd2; #1;
      if (txd_a !== 1'b1) pin_ok = 1'b0;
      if (bus_a.dout[0] == 1'b1) begin idx = 1; break; end
    end
    check_val("loop_rx_ready", idx, 32'd1);
    check_val("loop_pin_high", {31'd0, pin_ok}, 32'd1);
    bus_read(0, 4'd0, d);
    check_val("loop_dr", d, {24'd0, sb_q.pop_front()});
    wait_a_idle(400);
    bus_write(0, 4'd1, 32'd3);
`else
    bus_write(0, 4'd1, 32'd7);
    bus_read(0, 4'd1, d); check_val("noloop_ctrl", d, 32'd3);
    pin_ok = 1'b1;
`endif

    // Reset in mid-frame abandons the frame
    bus_write(0, 4'd0, 32'h00);
    repeat (30) @(negedge clk);
    check_val("midframe_txd_low", {31'd0, txd_a}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("midreset_txd", {31'd0, txd_a}, 32'd1);
    bus_a.addr = 4'd2; #1;
    check_val("midreset_busy", bus_a.dout, 32'd0);
    @(negedge clk); reset = 1'b0;
    bus_read(0, 4'd3, d); check_val("post_rst_cpb", d, 32'd217);
    bus_read(0, 4'd1, d); check_val("post_rst_ctrl", d, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
